// File: rtl/serial_tx_pkg.sv
// Shared definitions for the serial link: FSM state encoding, line levels
// and a width helper. Intended for reuse by the matching receiver.
package serial_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;

  // Counter width for a 0..n-1 range; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/baud_gen.sv
// Bit-period timer for the serial transmitter.
// Ports:
//   clk   - clock, rising edge
//   rst   - asynchronous active-high reset
//   clear - restart the bit period (counter back to 0 on this edge)
//   tick  - high on the last cycle of each bit period
module baud_gen
  import serial_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CNT_W = cnt_width(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_n;

  // Next count: wrap at the end of a bit period or on an explicit restart.
  always_comb begin
    cnt_n = cnt + CNT_W'(1);
    if (clear || (cnt == LAST)) begin
      cnt_n = '0;
    end
  end

  // tick is registered and tracks (cnt == LAST) of the updated count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      cnt  <= cnt_n;
      tick <= (cnt_n == LAST);
    end
  end

endmodule

// File: rtl/serial_tx.sv
// Parallel-in, serial-out frame transmitter: start bit, WIDTH data bits
// LSB first, stop bit; each bit lasts CLKS_PER_BIT cycles.
// Ports:
//   clk     - clock, rising edge
//   rst     - asynchronous active-high reset
//   load    - transmit request, accepted only while not busy
//   data_in - word captured on the accept edge
//   tx      - serial line, idles high
//   busy    - frame in progress
//   done    - one-cycle pulse when the frame completes
module serial_tx
  import serial_tx_pkg::*;
#(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  output logic             tx,
  output logic             busy,
  output logic             done
);

  localparam int unsigned IDX_W = cnt_width(WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  state_t           state, state_n;
  logic [WIDTH-1:0] shreg, shreg_n, shifted;
  logic [IDX_W-1:0] idx, idx_n;
  logic             tx_n, busy_n, done_n;
  logic             accept_c;
  logic             tick;

  // Accept only from IDLE, which is exactly when busy is low.
  assign accept_c = load && (state == IDLE);
  assign shifted  = shreg >> 1;

  baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk  (clk),
    .rst  (rst),
    .clear(accept_c),
    .tick (tick)
  );

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      shreg <= '0;
      idx   <= '0;
      tx    <= IDLE_LEVEL;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      shreg <= shreg_n;
      idx   <= idx_n;
      tx    <= tx_n;
      busy  <= busy_n;
      done  <= done_n;
    end
  end

  // Next-state and next-output logic; transitions happen on baud ticks.
  always_comb begin
    state_n = state;
    shreg_n = shreg;
    idx_n   = idx;
    tx_n    = tx;
    busy_n  = busy;
    done_n  = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept_c) begin
          state_n = START;
          shreg_n = data_in;
          idx_n   = '0;
          tx_n    = START_LEVEL;
          busy_n  = 1'b1;
        end
      end
      START: begin
        if (tick) begin
          state_n = DATA;
          idx_n   = '0;
          tx_n    = shreg[0];
        end
      end
      DATA: begin
        if (tick) begin
          if (idx == LAST_IDX) begin
            state_n = STOP;
            tx_n    = STOP_LEVEL;
          end else begin
            // Present the next LSB as the register shifts right.
            shreg_n = shifted;
            tx_n    = shifted[0];
            idx_n   = idx + IDX_W'(1);
          end
        end
      end
      STOP: begin
        if (tick) begin
          state_n = IDLE;
          tx_n    = IDLE_LEVEL;
          busy_n  = 1'b0;
          done_n  = 1'b1;
        end
      end
    endcase
  end

endmodule

// File: tb/tb_serial_tx.sv
// Scoreboard bench for serial_tx: a C=4 instance and a C=1 instance.
module tb_serial_tx;

  logic       clk;
  logic       rst;
  logic       load0, load1;
  logic [7:0] data0, data1;
  logic       tx0, busy0, done0;
  logic       tx1, busy1, done1;

  int checks   = 0;
  int failures = 0;

  logic [7:0] q0[$];
  logic [7:0] q1[$];

  serial_tx #(.WIDTH(8), .CLKS_PER_BIT(4)) dut (
    .clk(clk), .rst(rst), .load(load0), .data_in(data0),
    .tx(tx0), .busy(busy0), .done(done0)
  );

  serial_tx #(.WIDTH(8), .CLKS_PER_BIT(1)) dut1 (
    .clk(clk), .rst(rst), .load(load1), .data_in(data1),
    .tx(tx1), .busy(busy1), .done(done1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected per-cycle line level over a whole frame.
  function automatic logic [63:0] exp_frame(input logic [7:0] w, input int c);
    logic [63:0] v;
    int b;
    v = '0;
    for (int k = 0; k < 10 * c; k++) begin
      b = k / c;
      if (b == 0)      v[k] = 1'b0;
      else if (b <= 8) v[k] = w[b-1];
      else             v[k] = 1'b1;
    end
    return v;
  endfunction

  task automatic score(input string nm, input int n, input logic [63:0] smp,
                       input logic txv, input logic [7:0] w, input int c);
    logic [7:0] dec;
    for (int i = 0; i < 8; i++) dec[i] = smp[(1 + i) * c + c / 2];
    check({nm, "_len"}, 64'(n), 64'(10 * c));
    check({nm, "_bits"}, smp, exp_frame(w, c));
    check({nm, "_word"}, 64'(dec), 64'(w));
    check({nm, "_idle_after"}, 64'(txv), 64'd1);
  endtask

  // Monitors sample on the falling edge, away from the active edge.
  logic [63:0] smp0, smp1;
  int          n0 = 0, n1 = 0;
  int          idle0 = 100, gap0 = 0;
  int          done_cnt0 = 0, done_cnt1 = 0;
  logic        dprev0 = 1'b0, dprev1 = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      n0 = 0; smp0 = '0; dprev0 = 1'b0;
    end else begin
      if (busy0) begin
        if (n0 == 0) gap0 = idle0;
        idle0 = 0;
        if (n0 < 64) smp0[n0] = tx0;
        n0++;
      end else begin
        idle0++;
      end
      if (done0) begin
        check("done0_width", 64'(dprev0), 64'd0);
        if (q0.size() == 0) check("frame0_unexpected", 64'd1, 64'd0);
        else score("frame0", n0, smp0, tx0, q0.pop_front(), 4);
        done_cnt0++;
        n0 = 0; smp0 = '0;
      end
      dprev0 = done0;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      n1 = 0; smp1 = '0; dprev1 = 1'b0;
    end else begin
      if (busy1) begin
        if (n1 < 64) smp1[n1] = tx1;
        n1++;
      end
      if (done1) begin
        check("done1_width", 64'(dprev1), 64'd0);
        if (q1.size() == 0) check("frame1_unexpected", 64'd1, 64'd0);
        else score("frame1", n1, smp1, tx1, q1.pop_front(), 1);
        done_cnt1++;
        n1 = 0; smp1 = '0;
      end
      dprev1 = done1;
    end
  end

  task automatic send0(input logic [7:0] w, input bit push);
    @(negedge clk);
    load0 = 1'b1; data0 = w;
    if (push) q0.push_back(w);
    @(posedge clk);
    #1 load0 = 1'b0; data0 = 8'($urandom);
  endtask

  task automatic send1(input logic [7:0] w);
    @(negedge clk);
    load1 = 1'b1; data1 = w;
    q1.push_back(w);
    @(posedge clk);
    #1 load1 = 1'b0; data1 = 8'($urandom);
  endtask

  task automatic wait_frames(input string tag, input int t0, input int t1, input int budget);
    int cyc;
    cyc = 0;
    while (!(done_cnt0 >= t0 && done_cnt1 >= t1) && cyc < budget) begin
      @(posedge clk);
      cyc++;
    end
    check({tag, "_timeout"}, 64'(done_cnt0 >= t0 && done_cnt1 >= t1), 64'd1);
  endtask

  initial begin
    int base;
    int cyc;
    rst = 1'b0; load0 = 1'b0; load1 = 1'b0; data0 = '0; data1 = '0;

    // Asynchronous reset with no clock edge.
    #2 rst = 1'b1;
    #1;
    check("rst_tx", 64'(tx0), 64'd1);
    check("rst_busy", 64'(busy0), 64'd0);
    check("rst_done", 64'(done0), 64'd0);
    check("rst_tx1", 64'(tx1), 64'd1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single frame 0x55.
    send0(8'h55, 1'b1);
    check("busy_after_accept", 64'(busy0), 64'd1);
    check("tx_start", 64'(tx0), 64'd0);
    wait_frames("f55", 1, 0, 100);
    repeat (3) @(negedge clk);

    // Load during a frame must be ignored.
    base = done_cnt0;
    send0(8'hA5, 1'b1);
    repeat (9) @(posedge clk);
    #1 load0 = 1'b1; data0 = 8'hFF;
    @(posedge clk);
    #1 load0 = 1'b0;
    wait_frames("fa5", base + 1, 0, 100);
    repeat (60) @(posedge clk);
    #1;
    check("no_extra_frame", 64'(done_cnt0), 64'(base + 1));
    check("idle_busy", 64'(busy0), 64'd0);

    // Back-to-back with load held high.
    base = done_cnt0;
    @(negedge clk);
    load0 = 1'b1; data0 = 8'h00; q0.push_back(8'h00);
    @(posedge clk);
    #1 data0 = 8'hFF; q0.push_back(8'hFF);
    cyc = 0;
    while (busy0 && cyc < 200) begin
      @(posedge clk); #1; cyc++;
    end
    @(posedge clk);
    #1 load0 = 1'b0;
    check("b2b_second_busy", 64'(busy0), 64'd1);
    wait_frames("b2b", base + 2, 0, 200);
    check("b2b_gap", 64'(gap0), 64'd1);
    repeat (5) @(negedge clk);

    // Reset mid-frame, then a fresh frame.
    send0(8'h3C, 1'b0);
    repeat (17) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_tx", 64'(tx0), 64'd1);
    check("midrst_busy", 64'(busy0), 64'd0);
    check("midrst_done", 64'(done0), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    base = done_cnt0;
    send0(8'h81, 1'b1);
    wait_frames("f81", base + 1, 0, 100);

    // Single-cycle bit period.
    send1(8'hC3);
    wait_frames("c1", 0, 1, 50);

    repeat (5) @(negedge clk);
    check("q0_empty", 64'(q0.size()), 64'd0);
    check("q1_empty", 64'(q1.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
